// File: rtl/instr_sequencer_pkg.sv
// Shared field layout of the 9-bit control-unit input word {opcode, step, carry, zero}.
// Optional feature macro used by this block: SEQ_EARLY_END_EN.
package instr_sequencer_pkg;

  localparam int INSTIN_W  = 9;
  localparam int OPC_W     = 4;
  localparam int STEP_W    = 3;
  localparam int OPC_LSB   = 5;
  localparam int STEP_LSB  = 2;
  localparam int CARRY_BIT = 1;
  localparam int ZERO_BIT  = 0;

  function automatic logic [INSTIN_W-1:0] pack_instin(
    input logic [OPC_W-1:0]  opc,
    input logic [STEP_W-1:0] stp,
    input logic              carry,
    input logic              zero
  );
    logic [INSTIN_W-1:0] w;
    w = {INSTIN_W{1'b0}};
    w[OPC_LSB +: OPC_W]   = opc;
    w[STEP_LSB +: STEP_W] = stp;
    w[CARRY_BIT]          = carry;
    w[ZERO_BIT]           = zero;
    return w;
  endfunction

endpackage

// File: rtl/instr_sequencer_step_counter.sv
// T-step counter: wraps after STEPS-1, freezes while halting/halted.
// With SEQ_EARLY_END_EN defined, an idle control word at step >= 2 ends the instruction early.
module step_counter
  import instr_sequencer_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              freeze_i,
  input  logic              cw_idle_i,
  output logic [STEP_W-1:0] step_o
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic              early_end_s;

`ifdef SEQ_EARLY_END_EN
  assign early_end_s = cw_idle_i && (step_q >= 3'd2);
`else
  assign early_end_s = cw_idle_i & 1'b0;
`endif

  // Next-step selection: freeze has priority, then early end, then wrap.
  always_comb begin
    step_d = step_q;
    if (freeze_i) begin
      step_d = step_q;
    end else if (early_end_s) begin
      step_d = 3'd0;
    end else if (step_q == STEP_LAST) begin
      step_d = 3'd0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  // Step register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q <= 3'd0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction register, flags and halt state feeding the control unit; all instin fields registered.
// Optional feature macro: SEQ_EARLY_END_EN (early instruction end on idle control word).
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [7:0]          bus_in,
  input  logic                inregwa,
  input  logic                inregoa,
  input  logic                flagsin,
  input  logic                carry_in,
  input  logic                zero_in,
  input  logic                hlt,
  input  logic                cw_idle,
  output logic [INSTIN_W-1:0] instin,
  output logic [7:0]          opr_out,
  output logic                opr_oe,
  output logic [STEP_W-1:0]   step,
  output logic                halted
);

  logic [7:0]        ir_q, ir_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              halted_q, halted_d;
  logic              load_ok_s;
  logic [STEP_W-1:0] step_s;

  // A halt request at the same edge blocks any load.
  assign load_ok_s = !halted_q && !hlt;

  step_counter #(.STEPS(STEPS)) u_step_counter (
    .clk       (clk),
    .clr_n     (clr_n),
    .freeze_i  (halted_q | hlt),
    .cw_idle_i (cw_idle),
    .step_o    (step_s)
  );

  // Next-state for instruction register, flags and sticky halt.
  always_comb begin
    ir_d     = ir_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    halted_d = halted_q | hlt;
    if (load_ok_s && inregwa) begin
      ir_d = bus_in;
    end else begin
      ir_d = ir_q;
    end
    if (load_ok_s && flagsin) begin
      carry_d = carry_in;
      zero_d  = zero_in;
    end else begin
      carry_d = carry_q;
      zero_d  = zero_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ir_q     <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      halted_q <= halted_d;
    end
  end

  assign instin  = pack_instin(ir_q[7:4], step_s, carry_q, zero_q);
  assign step    = step_s;
  assign halted  = halted_q;
  assign opr_oe  = inregoa & ~halted_q;
  assign opr_out = opr_oe ? {4'h0, ir_q[3:0]} : 8'h00;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (STEPS=5); honours SEQ_EARLY_END_EN.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] bus_in;
  logic       inregwa, inregoa, flagsin, carry_in, zero_in, hlt, cw_idle;
  logic [8:0] instin;
  logic [7:0] opr_out;
  logic       opr_oe;
  logic [2:0] step;
  logic       halted;

  int n_cmp = 0;
  int n_mis = 0;

  instr_sequencer #(.STEPS(5)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .inregwa(inregwa), .inregoa(inregoa),
    .flagsin(flagsin), .carry_in(carry_in), .zero_in(zero_in), .hlt(hlt), .cw_idle(cw_idle),
    .instin(instin), .opr_out(opr_out), .opr_oe(opr_oe), .step(step), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_step(input logic [2:0] s);
    for (int k = 0; k < 10; k++) begin
      if (step == s) break;
      tick();
    end
    check_val("goto_step", 16'(step), 16'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; bus_in = 8'h00; inregwa = 1'b0; inregoa = 1'b0; flagsin = 1'b0;
    carry_in = 1'b0; zero_in = 1'b0; hlt = 1'b0; cw_idle = 1'b0;
    #2;
    check_val("rst_instin", 16'(instin), 16'h000);
    check_val("rst_step",   16'(step),   16'h0);
    check_val("rst_halted", 16'(halted), 16'h0);
    check_val("rst_oprout", 16'(opr_out), 16'h00);
    check_val("rst_oproe",  16'(opr_oe), 16'h0);
    #10;
    clr_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      check_val("run_step", 16'(step), 16'(i % 5));
      if (i == 0) check_val("run_instin0", 16'(instin), 16'h000);
      if (i == 1) check_val("run_instin1", 16'(instin), 16'h004);
      if (i == 2) check_val("run_instin2", 16'(instin), 16'h008);
      tick();
    end

    // IR load in step 1, visible in step 2
    goto_step(3'd1);
    bus_in = 8'h1E; inregwa = 1'b1;
    tick();
    inregwa = 1'b0;
    check_val("load_instin", 16'(instin), 16'h028);
    inregoa = 1'b1; #1;
    check_val("opr_out", 16'(opr_out), 16'h0E);
    check_val("opr_oe",  16'(opr_oe),  16'h1);
    inregoa = 1'b0; #1;
    check_val("opr_out_off", 16'(opr_out), 16'h00);

    // Flag capture, then hold across the wrap
    flagsin = 1'b1; carry_in = 1'b1; zero_in = 1'b0;
    tick();
    flagsin = 1'b0; carry_in = 1'b0; zero_in = 1'b1;
    check_val("flags_cap", 16'(instin[1:0]), 16'h2);
    goto_step(3'd0);
    check_val("flags_hold", 16'(instin), 16'h022);

    // inregwa and flagsin together
    goto_step(3'd1);
    bus_in = 8'h35; inregwa = 1'b1; flagsin = 1'b1; carry_in = 1'b0; zero_in = 1'b1;
    tick();
    inregwa = 1'b0; flagsin = 1'b0;
    check_val("load_and_flags", 16'(instin), 16'h069);

    // Load at the wrap edge
    goto_step(3'd4);
    bus_in = 8'h5A; inregwa = 1'b1;
    tick();
    inregwa = 1'b0;
    check_val("wrap_load", 16'(instin), 16'h0A1);

    // Halt beats simultaneous load and flag capture
    goto_step(3'd2);
    hlt = 1'b1; inregwa = 1'b1; bus_in = 8'hAA; flagsin = 1'b1; carry_in = 1'b1; zero_in = 1'b0;
    tick();
    hlt = 1'b0; inregwa = 1'b0; flagsin = 1'b0;
    check_val("halt_flag", 16'(halted), 16'h1);
    check_val("halt_instin", 16'(instin), 16'h0A9);
    inregoa = 1'b1; #1;
    check_val("halt_oproe",  16'(opr_oe),  16'h0);
    check_val("halt_oprout", 16'(opr_out), 16'h00);
    inregoa = 1'b0;
    repeat (10) tick();
    check_val("halt_frozen_step",   16'(step),   16'h2);
    check_val("halt_frozen_instin", 16'(instin), 16'h0A9);
    check_val("halt_sticky",        16'(halted), 16'h1);
    clr_n = 1'b0; #2;
    check_val("halt_clr_instin", 16'(instin), 16'h000);
    check_val("halt_clr_halted", 16'(halted), 16'h0);
    clr_n = 1'b1;

    // Async reset mid-cycle at step 3 with ir=2F
    goto_step(3'd1);
    bus_in = 8'h2F; inregwa = 1'b1;
    tick();
    inregwa = 1'b0;
    goto_step(3'd3);
    check_val("pre_async", 16'(instin), 16'h04C);
    inregoa = 1'b1; #1;
    check_val("pre_async_opr", 16'(opr_out), 16'h0F);
    #2;
    clr_n = 1'b0; #1;
    check_val("async_instin", 16'(instin), 16'h000);
    check_val("async_step",   16'(step),   16'h0);
    check_val("async_opr",    16'(opr_out), 16'h00);
    inregoa = 1'b0;
    #1;
    clr_n = 1'b1;
    tick();
    check_val("post_rst_fetch", 16'(instin), 16'h004);

    // Early end on idle control word; fetch steps never shortened
    goto_step(3'd0);
    cw_idle = 1'b1;
    tick();
    check_val("fetch_not_short", 16'(step), 16'h1);
    cw_idle = 1'b0;
    goto_step(3'd2);
    cw_idle = 1'b1;
    tick();
    cw_idle = 1'b0;
`ifdef SEQ_EARLY_END_EN
    check_val("early_end", 16'(step), 16'h0);
`else
    check_val("early_end", 16'(step), 16'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Upstream feeder for the control unit: holds the instruction register, the T-step counter and the carry/zero flags register, and assembles the 9-bit control-unit input {opcode[3:0], step[2:0], carry, zero}. It consumes the control unit's `inregwa`, `inregoa`, `flagsin` and `hlt` outputs, closing the fetch/execute loop. All state is registered, so there is no combinational path from the control-unit outputs back to `instin`.

## Interface
- `STEPS`, default 5: T-steps per instruction; legal range 3..8.
- `clk`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `bus_in`  in  8  data bus; source for instruction register loads.
- `inregwa`  in  1  load instruction register from `bus_in`.
- `inregoa`  in  1  drive operand nibble toward the bus.
- `flagsin`  in  1  capture `carry_in` and `zero_in`.
- `carry_in`  in  1  ALU carry.
- `zero_in`  in  1  ALU zero.
- `hlt`  in  1  halt request from the control unit.
- `cw_idle`  in  1  current control word is all zero (used only with SEQ_EARLY_END_EN).
- `instin`  out  9  {ir[7:4], step, carry_q, zero_q} to the control unit.
- `opr_out`  out  8  {4'h0, ir[3:0]} when `inregoa`=1, else 8'h00.
- `opr_oe`  out  1  equals `inregoa` while not halted.
- `step`  out  3  current T-step.
- `halted`  out  1  sticky halt status.

## Operation
- Reset, async on `clr_n`=0: ir=8'h00, step=0, carry_q=0, zero_q=0, halted=0. Hence `instin`=9'h000, `opr_out`=8'h00, `opr_oe`=0.
- Step counter runs 0,1,…,STEPS-1, then returns to 0. Each instruction therefore occupies exactly STEPS cycles. Values ≥STEPS never occur.
- Instruction register loads `bus_in` at a rising edge when `inregwa`=1 and the block is not halted. Otherwise it holds.
- Flags register updates {carry_q, zero_q} at a rising edge when `flagsin`=1 and the block is not halted. It is not cleared between instructions.
- Halt: a rising edge with `hlt`=1 sets `halted`. From then until reset, step, ir and flags freeze, `opr_oe`=0 and `opr_out`=0. Only `clr_n` clears the halt.
- Simultaneous events at the same edge:
  - `hlt` with `inregwa` or `flagsin`: the halt wins and no load occurs.
  - `inregwa` with `flagsin`: both take effect.
  - `inregwa` at the wrap edge: the load takes effect and step returns to 0.
- Reset mid-instruction returns to step 0 with ir=0. The next cycle is a fetch (opcode 0 = NOP).

## Timing
- `instin`, `step`, `halted`: registered outputs, valid one clock-to-q after the edge.
- `opr_out`, `opr_oe`: combinational from `inregoa` and registered ir/halted, same cycle.
- A load via `inregwa` in step 1 is visible in `instin[8:5]` during step 2.
- A flag capture via `flagsin` is visible in `instin[1:0]` in the next cycle.
- `halted` asserts in the cycle after `hlt` is sampled. Step does not advance past the halting step.

## Configuration
- `SEQ_EARLY_END_EN` defined: at a rising edge where step ≥ 2, `cw_idle`=1 and the block is not halted, the next step is 0 instead of step+1. This skips the idle tail of short instructions.
- `SEQ_EARLY_END_EN` undefined: `cw_idle` is ignored and every instruction takes the full STEPS cycles.
- Steps 0 and 1 (fetch) are never shortened.

## Structure
- Shared package: `INSTIN_W`=9, `OPC_W`=4, `STEP_W`=3, field offsets OPC_LSB=5, STEP_LSB=2, CARRY_BIT=1, ZERO_BIT=0.
- One sub-module: `step_counter`, containing the step register, wrap logic, halt freeze and the optional early-end logic.
- Instruction register, flags and output assembly live in the top level.

## Test plan
- Reset, then free-run 12 cycles with no controls → step sequence 0,1,2,3,4,0,1,2,3,4,0,1. `instin` reads 9'h000, 9'h004, 9'h008 for steps 0, 1, 2.
- `bus_in`=8'h1E with `inregwa` during step 1 → step 2 `instin`=9'b0001_010_00. With `inregoa`=1, `opr_out`=8'h0E and `opr_oe`=1.
- `flagsin`=1 with carry_in=1, zero_in=0 → next cycle `instin[1:0]`=2'b10. The value holds across a step wrap.
- `hlt`=1 and `inregwa`=1 with `bus_in`=8'hAA at step 2 → `halted`=1, ir unchanged, step frozen at 2 for 10 cycles, then `clr_n` pulse → all zero.
- Assert `clr_n`=0 asynchronously mid-cycle at step 3 with ir=8'h2F → outputs zero immediately, without waiting for a clock edge.
- With `SEQ_EARLY_END_EN` defined: `cw_idle`=1 at step 2 → next step 0. With it undefined, the same stimulus → step 3.
